// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 operator datapath.
package ym3438_pkg;

  localparam int SLOT_CNT = 24;  // slots per sample frame
  localparam int FB_CH    = 6;   // channels with operator-1 feedback history
  localparam int LOGSIN_W = 12;  // log-sin attenuation width (4.8 fixed point)

  typedef logic [4:0]         slot_t;
  typedef logic [9:0]         phase_t;
  typedef logic signed [13:0] op_sample_t;

  // Fold a full-wave phase onto the first quarter: the second quarter of each
  // half-wave mirrors the first, so the index is bit-inverted when phase[8] is set.
  function automatic logic [7:0] quarter_idx(input phase_t ph);
    return ph[8] ? ~ph[7:0] : ph[7:0];
  endfunction

endpackage

// File: rtl/ym3438_op_phase_if.sv
// Slot bus between the phase generator / operator output side and the
// phase + log-sin stage.
interface ym3438_op_phase_if;
  import ym3438_pkg::*;

  logic                c1;
  logic                c2;
  logic                fsm_sync;
  phase_t              pg_in;
  op_sample_t          mod_in;
  logic [2:0]          fb;
  logic                op1_we;
  logic [2:0]          op1_ch;
  op_sample_t          op1_out;
  logic [LOGSIN_W-1:0] logsin_out;
  logic                sign_out;
  slot_t               slot_out;

  modport master (
    output c1, c2, fsm_sync, pg_in, mod_in, fb, op1_we, op1_ch, op1_out,
    input  logsin_out, sign_out, slot_out
  );

  modport slave (
    input  c1, c2, fsm_sync, pg_in, mod_in, fb, op1_we, op1_ch, op1_out,
    output logsin_out, sign_out, slot_out
  );

endinterface

// File: rtl/ym3438_logsin_rom.sv
// Quarter-wave log-sin table: entry i = round(-log2(sin((2i+1)*pi/1024))*256).
module ym3438_logsin_rom
  import ym3438_pkg::*;
(
  input  logic [7:0]          idx,
  output logic [LOGSIN_W-1:0] logsin
);

  localparam logic [LOGSIN_W-1:0] LOGSIN_TABLE [256] = '{
    12'h859, 12'h6c3, 12'h607, 12'h58b, 12'h52e, 12'h4e4, 12'h4a6, 12'h471,
    12'h443, 12'h41a, 12'h3f5, 12'h3d3, 12'h3b5, 12'h398, 12'h37e, 12'h365,
    12'h34e, 12'h339, 12'h324, 12'h311, 12'h2ff, 12'h2ed, 12'h2dc, 12'h2cd,
    12'h2bd, 12'h2af, 12'h2a0, 12'h293, 12'h286, 12'h279, 12'h26d, 12'h261,
    12'h256, 12'h24b, 12'h240, 12'h236, 12'h22c, 12'h222, 12'h218, 12'h20f,
    12'h206, 12'h1fd, 12'h1f5, 12'h1ec, 12'h1e4, 12'h1dc, 12'h1d4, 12'h1cd,
    12'h1c5, 12'h1be, 12'h1b7, 12'h1b0, 12'h1a9, 12'h1a2, 12'h19b, 12'h195,
    12'h18f, 12'h188, 12'h182, 12'h17c, 12'h177, 12'h171, 12'h16b, 12'h166,
    12'h160, 12'h15b, 12'h155, 12'h150, 12'h14b, 12'h146, 12'h141, 12'h13c,
    12'h137, 12'h133, 12'h12e, 12'h129, 12'h125, 12'h121, 12'h11c, 12'h118,
    12'h114, 12'h10f, 12'h10b, 12'h107, 12'h103, 12'h0ff, 12'h0fb, 12'h0f8,
    12'h0f4, 12'h0f0, 12'h0ec, 12'h0e9, 12'h0e5, 12'h0e2, 12'h0de, 12'h0db,
    12'h0d7, 12'h0d4, 12'h0d1, 12'h0cd, 12'h0ca, 12'h0c7, 12'h0c4, 12'h0c1,
    12'h0be, 12'h0bb, 12'h0b8, 12'h0b5, 12'h0b2, 12'h0af, 12'h0ac, 12'h0a9,
    12'h0a7, 12'h0a4, 12'h0a1, 12'h09f, 12'h09c, 12'h099, 12'h097, 12'h094,
    12'h092, 12'h08f, 12'h08d, 12'h08a, 12'h088, 12'h086, 12'h083, 12'h081,
    12'h07f, 12'h07d, 12'h07a, 12'h078, 12'h076, 12'h074, 12'h072, 12'h070,
    12'h06e, 12'h06c, 12'h06a, 12'h068, 12'h066, 12'h064, 12'h062, 12'h060,
    12'h05e, 12'h05c, 12'h05b, 12'h059, 12'h057, 12'h055, 12'h053, 12'h052,
    12'h050, 12'h04e, 12'h04d, 12'h04b, 12'h04a, 12'h048, 12'h046, 12'h045,
    12'h043, 12'h042, 12'h040, 12'h03f, 12'h03e, 12'h03c, 12'h03b, 12'h039,
    12'h038, 12'h037, 12'h035, 12'h034, 12'h033, 12'h031, 12'h030, 12'h02f,
    12'h02e, 12'h02d, 12'h02b, 12'h02a, 12'h029, 12'h028, 12'h027, 12'h026,
    12'h025, 12'h024, 12'h023, 12'h022, 12'h021, 12'h020, 12'h01f, 12'h01e,
    12'h01d, 12'h01c, 12'h01b, 12'h01a, 12'h019, 12'h018, 12'h017, 12'h017,
    12'h016, 12'h015, 12'h014, 12'h014, 12'h013, 12'h012, 12'h011, 12'h011,
    12'h010, 12'h00f, 12'h00f, 12'h00e, 12'h00d, 12'h00d, 12'h00c, 12'h00c,
    12'h00b, 12'h00a, 12'h00a, 12'h009, 12'h009, 12'h008, 12'h008, 12'h007,
    12'h007, 12'h007, 12'h006, 12'h006, 12'h005, 12'h005, 12'h005, 12'h004,
    12'h004, 12'h004, 12'h003, 12'h003, 12'h003, 12'h002, 12'h002, 12'h002,
    12'h002, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001,
    12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000
  };

  assign logsin = LOGSIN_TABLE[idx];

endmodule

// File: rtl/ym3438_op_phase.sv
// Operator phase modulation + quarter-wave log-sin lookup, time-multiplexed
// over the slot frame, with per-channel operator-1 feedback history.
module ym3438_op_phase #(
  parameter int SLOTS = ym3438_pkg::SLOT_CNT,
  parameter int FB_CH = ym3438_pkg::FB_CH
) (
  input logic              MCLK,
  input logic              reset,
  ym3438_op_phase_if.slave bus
);
  import ym3438_pkg::*;

  // stage 0 (sampled on c1)
  phase_t     pg_reg;
  op_sample_t mod_reg;
  logic [2:0] fb_reg;

  // slot counter and stage 1 / stage 2 registers (advanced on c2)
  slot_t               slot_reg;
  slot_t               slot_next;
  phase_t              phase_reg;
  slot_t               slot1_reg;
  logic [LOGSIN_W-1:0] logsin_reg;
  logic                sign_reg;
  slot_t               slot2_reg;

  // feedback history: hist0 = newest operator-1 sample, hist1 = the one before
  op_sample_t       hist0_reg [FB_CH];
  op_sample_t       hist1_reg [FB_CH];
  logic [FB_CH-1:0] hist_we;

  // stage 1 combinational terms
  logic               is_op1;
  logic [2:0]         ch;
  logic signed [14:0] fb_sum;
  logic signed [14:0] fb_scaled;
  logic [3:0]         fb_shift;
  phase_t             mod_term;
  phase_t             phase_next;

  logic [7:0]          rom_idx;
  logic [LOGSIN_W-1:0] rom_data;

  // Next slot: wrap at the end of the frame; a frame sync overrides the count.
  always_comb begin
    slot_next = slot_reg + 5'd1;
    if (bus.fsm_sync || (slot_reg == 5'(SLOTS - 1))) begin
      slot_next = '0;
    end
  end

  // Modulation select and phase add; wrap-around of the 10-bit phase is intended.
  always_comb begin
    is_op1    = (slot_reg < 5'(FB_CH));
    ch        = is_op1 ? slot_reg[2:0] : 3'd0;
    fb_sum    = {hist0_reg[ch][13], hist0_reg[ch]} + {hist1_reg[ch][13], hist1_reg[ch]};
    fb_shift  = 4'd10 - {1'b0, fb_reg};
    fb_scaled = fb_sum >>> fb_shift;
    if (!is_op1) begin
      mod_term = mod_reg[10:1];
    end else if (fb_reg != 3'd0) begin
      mod_term = fb_scaled[9:0];
    end else begin
      mod_term = '0;
    end
    phase_next = pg_reg + mod_term;
  end

  assign rom_idx = quarter_idx(phase_reg);

  ym3438_logsin_rom u_rom (
    .idx    (rom_idx),
    .logsin (rom_data)
  );

  // Per-channel write strobes; channels beyond the history depth never match.
  for (genvar gi = 0; gi < FB_CH; gi++) begin : g_hist_we
    assign hist_we[gi] = bus.op1_we && (bus.op1_ch == 3'(gi));
  end

  // Feedback history shift; runs on any edge, independent of c1/c2.
  always_ff @(posedge MCLK) begin
    for (int i = 0; i < FB_CH; i++) begin
      if (reset) begin
        hist0_reg[i] <= '0;
        hist1_reg[i] <= '0;
      end else if (hist_we[i]) begin
        hist1_reg[i] <= hist0_reg[i];
        hist0_reg[i] <= bus.op1_out;
      end
    end
  end

  // Stage 0 input capture on c1.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      pg_reg  <= '0;
      mod_reg <= '0;
      fb_reg  <= '0;
    end else if (bus.c1) begin
      pg_reg  <= bus.pg_in;
      mod_reg <= bus.mod_in;
      fb_reg  <= bus.fb;
    end
  end

  // Slot counter and the two pipeline stages advance together on c2.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      slot_reg   <= '0;
      phase_reg  <= '0;
      slot1_reg  <= '0;
      logsin_reg <= '0;
      sign_reg   <= 1'b0;
      slot2_reg  <= '0;
    end else if (bus.c2) begin
      slot_reg   <= slot_next;
      phase_reg  <= phase_next;
      slot1_reg  <= slot_reg;
      logsin_reg <= rom_data;
      sign_reg   <= phase_reg[9];
      slot2_reg  <= slot1_reg;
    end
  end

  assign bus.logsin_out = logsin_reg;
  assign bus.sign_out   = sign_reg;
  assign bus.slot_out   = slot2_reg;

  // Bits of the modulation sample and scaled feedback that never reach the phase.
  logic unused_bits;
  assign unused_bits = &{1'b0, mod_reg[13:11], mod_reg[0], fb_scaled[14:10]};

endmodule

// File: tb/tb_ym3438_op_phase.sv
// Directed bench for the operator phase / log-sin stage.
module tb_ym3438_op_phase;

  logic MCLK = 1'b0;
  logic reset;

  ym3438_op_phase_if bus ();

  ym3438_op_phase dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 MCLK = ~MCLK;

  int errors   = 0;
  int checks   = 0;
  int cur_slot = 0;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit c1v, input bit c2v, input logic [9:0] pg,
                       input logic [13:0] md, input logic [2:0] fbv,
                       input bit sync = 1'b0, input bit we = 1'b0,
                       input logic [2:0] wch = 3'd0, input logic [13:0] wdat = 14'd0);
    bus.c1       = c1v;
    bus.c2       = c2v;
    bus.pg_in    = pg;
    bus.mod_in   = md;
    bus.fb       = fbv;
    bus.fsm_sync = sync;
    bus.op1_we   = we;
    bus.op1_ch   = wch;
    bus.op1_out  = wdat;
    tick();
    bus.c1       = 1'b0;
    bus.c2       = 1'b0;
    bus.fsm_sync = 1'b0;
    bus.op1_we   = 1'b0;
  endtask

  task automatic bump_slot();
    cur_slot = (cur_slot == 23) ? 0 : cur_slot + 1;
  endtask

  // One full slot: sample on a c1 edge, then advance on a c2 edge.
  task automatic slot_step(input logic [9:0] pg, input logic [13:0] md, input logic [2:0] fbv);
    drive(1'b1, 1'b0, pg, md, fbv);
    drive(1'b0, 1'b1, pg, md, fbv);
    bump_slot();
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 24 && cur_slot != target; n++) begin
      slot_step(10'd0, 14'd0, 3'd0);
    end
  endtask

  task automatic check_out(input string tag, input int s, input logic [11:0] exp_ls, input logic exp_sg);
    $display("slot %0d %s: logsin=%03h sign=%0b slot_out=%0d", s, tag,
             bus.logsin_out, bus.sign_out, bus.slot_out);
    check({tag, "_slot"}, 16'(bus.slot_out), 16'(s));
    check({tag, "_logsin"}, 16'(bus.logsin_out), 16'(exp_ls));
    check({tag, "_sign"}, 16'(bus.sign_out), 16'(exp_sg));
  endtask

  // Process one slot, push one filler slot so the result reaches the output, check it.
  task automatic probe(input string tag, input logic [9:0] pg, input logic [13:0] md,
                       input logic [2:0] fbv, input logic [11:0] exp_ls, input logic exp_sg);
    int s;
    s = cur_slot;
    slot_step(pg, md, fbv);
    slot_step(10'd0, 14'd0, 3'd0);
    check_out(tag, s, exp_ls, exp_sg);
  endtask

  task automatic write_op1(input logic [2:0] wch, input logic [13:0] wdat);
    drive(1'b0, 1'b0, 10'd0, 14'd0, 3'd0, 1'b0, 1'b1, wch, wdat);
  endtask

  initial begin
    int s;
    bus.c1 = 1'b0; bus.c2 = 1'b0; bus.fsm_sync = 1'b0;
    bus.pg_in = '0; bus.mod_in = '0; bus.fb = '0;
    bus.op1_we = 1'b0; bus.op1_ch = '0; bus.op1_out = '0;

    // power-on reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    cur_slot = 0;
    check("rst_logsin", 16'(bus.logsin_out), 16'h000);
    check("rst_sign", 16'(bus.sign_out), 16'h0);
    check("rst_slot", 16'(bus.slot_out), 16'h0);

    // basic lookup at phase 0
    run_to(6);
    probe("phase0", 10'h000, 14'h0000, 3'd0, 12'h859, 1'b0);

    // quarter mirror and sign
    run_to(10);
    probe("mirror_pos", 10'h1FF, 14'h0000, 3'd0, 12'h859, 1'b0);
    probe("mirror_neg", 10'h3FF, 14'h0000, 3'd0, 12'h859, 1'b1);

    // modulation wrap-around: 0x3F0 + 0x020 -> 0x010
    probe("wrap_up", 10'h3F0, 14'h0040, 3'd0, 12'h34e, 1'b0);
    // negative modulation: 0x030 + (-0x020) -> 0x010
    probe("wrap_neg", 10'h030, 14'h3FC0, 3'd0, 12'h34e, 1'b0);
    probe("idx40", 10'h040, 14'h0000, 3'd0, 12'h160, 1'b0);

    // c1 and c2 on the same edge: advance uses the previously sampled phase
    s = cur_slot;
    drive(1'b1, 1'b0, 10'h040, 14'h0000, 3'd0);
    drive(1'b1, 1'b1, 10'h1FF, 14'h0000, 3'd0);
    bump_slot();
    drive(1'b0, 1'b1, 10'h1FF, 14'h0000, 3'd0);
    bump_slot();
    check("c1c2_old_slot", 16'(bus.slot_out), 16'(s));
    check("c1c2_old_logsin", 16'(bus.logsin_out), 16'h160);
    drive(1'b0, 1'b1, 10'h1FF, 14'h0000, 3'd0);
    bump_slot();
    check("c1c2_new_slot", 16'(bus.slot_out), 16'((s + 1) % 24));
    check("c1c2_new_logsin", 16'(bus.logsin_out), 16'h859);

    // feedback on channel 2: hist = {0x400, 0x400}, s = 0x800
    write_op1(3'd2, 14'h0400);
    write_op1(3'd2, 14'h0400);
    run_to(2);
    probe("fb7", 10'h000, 14'h0000, 3'd7, 12'h000, 1'b0);
    run_to(2);
    probe("fb0", 10'h000, 14'h1555, 3'd0, 12'h859, 1'b0);
    run_to(2);
    probe("fb1", 10'h000, 14'h0000, 3'd1, 12'h52e, 1'b0);

    // same-edge history write and read on channel 1
    run_to(1);
    s = cur_slot;
    drive(1'b1, 1'b0, 10'h000, 14'h0000, 3'd7);
    drive(1'b0, 1'b1, 10'h000, 14'h0000, 3'd7, 1'b0, 1'b1, 3'd1, 14'h0400);
    bump_slot();
    slot_step(10'd0, 14'd0, 3'd0);
    check_out("wr_rd_same", s, 12'h859, 1'b0);
    run_to(1);
    probe("wr_rd_next", 10'h000, 14'h0000, 3'd7, 12'h07f, 1'b0);

    // write to a channel without history is ignored (slot 6 uses mod_in anyway)
    write_op1(3'd6, 14'h1FFF);
    run_to(0);
    probe("ch_oob", 10'h000, 14'h0000, 3'd0, 12'h859, 1'b0);

    // frame sync at counter 17
    run_to(17);
    drive(1'b1, 1'b0, 10'h040, 14'h0000, 3'd0);
    drive(1'b0, 1'b1, 10'h040, 14'h0000, 3'd0, 1'b1);
    cur_slot = 0;
    slot_step(10'd0, 14'd0, 3'd0);
    check("sync_last_slot", 16'(bus.slot_out), 16'd17);
    check("sync_last_logsin", 16'(bus.logsin_out), 16'h160);
    slot_step(10'd0, 14'd0, 3'd0);
    check("sync_restart_slot", 16'(bus.slot_out), 16'd0);

    // mid-frame reset clears outputs and history
    write_op1(3'd0, 14'h0400);
    write_op1(3'd0, 14'h0400);
    run_to(7);
    probe("pre_rst", 10'h3FF, 14'h0000, 3'd0, 12'h859, 1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b1, 10'h123, 14'h0040, 3'd7);
    reset = 1'b0;
    cur_slot = 0;
    check("midrst_logsin", 16'(bus.logsin_out), 16'h000);
    check("midrst_sign", 16'(bus.sign_out), 16'h0);
    check("midrst_slot", 16'(bus.slot_out), 16'h0);
    probe("post_rst_fb", 10'h000, 14'h0000, 3'd7, 12'h859, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ym3438_op_phase.md
Name: ym3438_op_phase

Overview:
- Operator phase/log-sin stage directly downstream of the phase generator.
- Each slot it takes the 10-bit phase from the phase generator and adds the modulation term.
  - Operator 1 slots use channel feedback; all other slots use the modulation input.
- The modulated phase is folded to a quarter wave and looked up in a log-sin ROM.
- Output is a 12-bit attenuation plus sign, which feeds the envelope adder / exp stage.
- Time-multiplexed over 24 slots with internal per-channel feedback history.

Parameters:
- SLOTS, 24, slots per sample frame; the slot counter wraps at SLOTS-1.
- FB_CH, 6, channels with feedback history (operator 1 occupies slots 0..FB_CH-1).

Ports:
- MCLK  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on MCLK rising edge.
- c1  in  1  input-sample enable: pg_in, mod_in and fb are registered on MCLK edges with c1=1.
- c2  in  1  slot-advance enable: pipeline and slot counter step on MCLK edges with c2=1.
- fsm_sync  in  1  marks slot 0 when high together with c2; reloads slot counter to 0.
- pg_in  in  10  phase from phase generator for the current slot (pg_out[19:10]).
- mod_in  in  14  signed modulation from the operator selected by the algorithm (0 when none).
- fb  in  3  feedback level of the current slot's channel; 0 = off.
- op1_we  in  1  write strobe: new operator-1 output is available.
- op1_ch  in  3  channel 0..5 of the operator-1 output being written.
- op1_out  in  14  signed operator-1 output sample.
- logsin_out  out  12  log-sin attenuation (4.8 fixed point).
- sign_out  out  1  waveform sign (phase bit 9).
- slot_out  out  5  slot number that logsin_out/sign_out belong to.

Behaviour:
- Reset: logsin_out=0, sign_out=0, slot_out=0, slot counter=0, all feedback history cleared to 0, pipeline registers zeroed.
  - Reset asserted mid-frame takes effect on that edge regardless of c1/c2.
  - The first valid output follows 2 c2 steps after reset deassert.
- Slot counter: increments on each c2 edge and wraps SLOTS-1 -> 0.
  - fsm_sync&c2 forces it to 0, overriding the increment.
- Stage 0 (c1): register pg_in, mod_in, fb.
- Stage 1 (c2), modulation term m (10-bit):
  - slot < FB_CH and fb != 0: s = hist0[ch] + hist1[ch] (15-bit signed sum); m = (s >>> (10 - fb))[9:0], arithmetic shift.
  - slot < FB_CH and fb = 0: m = 0 (mod_in ignored).
  - otherwise: m = mod_in[10:1].
  - phase = (pg_in + m) mod 1024. No saturation; wrap-around is required.
- Stage 2 (c2):
  - idx = phase[8] ? ~phase[7:0] : phase[7:0].
  - logsin_out = ROM[idx], where ROM[i] = round(-log2(sin((2i+1)*pi/1024))*256), 12-bit unsigned.
  - sign_out = phase[9]; slot_out = slot of that sample.
- Latency: exactly 2 c2 steps from stage-1 slot to output.
- Feedback history write:
  - On op1_we: hist1[op1_ch] <= hist0[op1_ch], then hist0[op1_ch] <= op1_out.
  - Independent of c1/c2 gating (any MCLK edge).
  - op1_ch >= FB_CH: write ignored.
- Same-edge read and write of the same channel: stage 1 uses the pre-write values; the new value is visible from the next edge.
- c1 and c2 both high on one edge: sampling and advance both occur; stage 1 uses the previously registered inputs.
- No handshake back-pressure: the stage runs free; the upstream provider must present data every slot.

Decomposition:
- Shared package ym3438_pkg:
  - SLOT_CNT=24, FB_CH=6.
  - Slot-index type (5-bit), phase type (10-bit), signed op-sample type (14-bit).
  - LOGSIN_W=12.
- Sub-module ym3438_logsin_rom: 256x12 combinational table, input idx[7:0], output logsin[11:0]. Kept separate so the exp ROM stage can share the generation flow.
- Top holds: slot counter, feedback RAM (6x2x14 flops), 2-stage pipeline.

Test Plan:
- Reset then pg_in=0, fb=0, mod_in=0 on slot 6 -> 2 c2 steps later slot_out=6, logsin_out=ROM[0]=0x859, sign_out=0.
- Quarter mirror and sign:
  - pg_in=0x1FF on slot 10 -> idx=0x00, logsin_out=0x859, sign_out=0.
  - pg_in=0x3FF -> same logsin_out, sign_out=1.
- Wrap-around: pg_in=0x3F0, mod_in=0x0040 (m=0x020) on slot 12 -> phase=0x010, sign_out=0, logsin_out=ROM[0x10].
- Feedback:
  - Write op1_out=0x0400 twice to ch 2; then slot 2 with fb=7, pg_in=0 -> s=0x0800, m=0x0800>>>3=0x100, logsin_out=ROM[0xFF]=0, sign_out=0.
  - Same slot with fb=0 -> m=0.
- Simultaneous write and read: hist of ch 1 = {0,0}; op1_we with ch 1 on the same edge as the slot-1 stage-1 update -> that output uses m=0; the next frame uses the new value.
- Sync and reset mid-frame:
  - fsm_sync at counter 17 -> next slot_out sequence restarts at 0.
  - reset at slot 9 -> outputs 0 and history cleared (fb=7 on slot 0 afterwards gives m=0).
